// File: rtl/spi_master_byte.sv
// spi_master_byte: byte-wide SPI master, mode 0 (CPOL=0, CPHA=0).
// Accepts one byte per valid/ready handshake, shifts it out on o_MOSI while
// capturing i_MISO, and returns the received byte with a one-cycle strobe.
//
// Parameters:
//   CLK_DIV     i_clk cycles per SCK half-period (>= 1)
// Ports:
//   i_clk       system clock, rising edge
//   i_sys_rst   synchronous active-high reset
//   i_tx_data   byte to send, sampled on handshake
//   i_tx_valid  transfer request
//   o_tx_ready  high only while idle
//   i_cs_hold   keep o_cs low after the byte completes
//   o_rx_data   last received byte, held between strobes
//   o_rx_valid  one-cycle strobe when a byte completes
//   o_sck       SPI clock, idles low
//   o_MOSI      serial data out
//   i_MISO      serial data in
//   o_cs        chip select, active low
// Configuration:
//   SPI_MASTER_MSB_FIRST_EN  defined: bit7 first on MOSI/MISO; undefined: bit0 first.
module spi_master_byte #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_sys_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_cs_hold,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_sck,
  output logic       o_MOSI,
  input  logic       i_MISO,
  output logic       o_cs
);

  localparam int unsigned CNT_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned EDGE_W = 5;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(15);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [7:0]        tx_sh;
  logic [7:0]        rx_sh;

  // Bit that goes on the wire first from a given shift-register value
  function automatic logic first_bit(input logic [7:0] d);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return d[7];
`else
    return d[0];
`endif
  endfunction

  // Discard the bit just transmitted
  function automatic logic [7:0] tx_shift(input logic [7:0] d);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return {d[6:0], 1'b0};
`else
    return {1'b0, d[7:1]};
`endif
  endfunction

  // Insert a sampled bit so that after 8 samples the byte is in natural order
  function automatic logic [7:0] rx_shift(input logic [7:0] d, input logic b);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return {d[6:0], b};
`else
    return {b, d[7:1]};
`endif
  endfunction

  // Control FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      edge_cnt   <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      o_tx_ready <= 1'b1;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_sck      <= 1'b0;
      o_MOSI     <= 1'b0;
      o_cs       <= 1'b1;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_tx_valid) begin
            state      <= SETUP;
            o_tx_ready <= 1'b0;
            o_cs       <= 1'b0;
            tx_sh      <= i_tx_data;
            o_MOSI     <= first_bit(i_tx_data);
            rx_sh      <= '0;
            cnt        <= '0;
            edge_cnt   <= '0;
          end else if (!i_cs_hold) begin
            o_cs <= 1'b1;
          end
        end
        // CS-to-first-edge setup; leaves with the first rising SCK edge
        SETUP: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            o_sck    <= 1'b1;
            edge_cnt <= EDGE_W'(1);
            rx_sh    <= rx_shift(rx_sh, i_MISO);
            state    <= XFER;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        XFER: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            o_sck    <= ~o_sck;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (!o_sck) begin
              rx_sh <= rx_shift(rx_sh, i_MISO);
            end else if (edge_cnt == EDGE_LAST) begin
              // 16th toggle: last falling edge, byte complete
              state      <= DONE;
              o_rx_data  <= rx_sh;
              o_rx_valid <= 1'b1;
            end else begin
              tx_sh  <= tx_shift(tx_sh);
              o_MOSI <= first_bit(tx_shift(tx_sh));
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          o_tx_ready <= 1'b1;
          if (!i_cs_hold) begin
            o_cs <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Self-checking bench for spi_master_byte (CLK_DIV=2). A slave model drives
// i_MISO and captures o_MOSI per rising SCK; a scoreboard holds the expected
// tx/rx bytes and is checked on every o_rx_valid strobe.
module tb_spi_master_byte;

  localparam int unsigned CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       i_sys_rst = 1'b1;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready;
  logic       i_cs_hold = 1'b0;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_sck;
  logic       o_MOSI;
  logic       i_MISO = 1'b0;
  logic       o_cs;

  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;
  int total_rises = 0;
  int rcnt = 0;
  logic       prev_sck = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] er, et;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] miso_q[$];

  spi_master_byte #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk      (clk),
    .i_sys_rst  (i_sys_rst),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .i_cs_hold  (i_cs_hold),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .o_sck      (o_sck),
    .o_MOSI     (o_MOSI),
    .i_MISO     (i_MISO),
    .o_cs       (o_cs)
  );

  always #5 clk = ~clk;

  // Wire position k (0 = first bit on the wire) to byte bit index
  function automatic int bit_idx(input int k);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic miso_bit(input logic [7:0] b, input int k);
    return b[bit_idx(k % 8)];
  endfunction

  // Slave model and scoreboard checker
  always @(negedge clk) begin
    if (i_sys_rst) begin
      rcnt     = 0;
      prev_sck = 1'b0;
    end else begin
      if (o_sck === 1'b1 && prev_sck === 1'b0) begin
        mosi_cap[bit_idx(rcnt % 8)] = o_MOSI;
        rcnt++;
        total_rises++;
      end
      prev_sck = o_sck;
      if (o_rx_valid === 1'b1) begin
        strobes++;
        vectors++;
        if (exp_rx_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_strobe: rx_data=%h, no byte expected", o_rx_data);
        end else begin
          er = exp_rx_q.pop_front();
          et = exp_tx_q.pop_front();
          if (miso_q.size() > 0) void'(miso_q.pop_front());
          if (o_rx_data !== er) begin
            miscompares++;
            $display("FAIL sb_rx_data: got %h expected %h", o_rx_data, er);
          end
          vectors++;
          if (mosi_cap !== et) begin
            miscompares++;
            $display("FAIL sb_mosi_byte: got %h expected %h", mosi_cap, et);
          end
          vectors++;
          if (rcnt != 8) begin
            miscompares++;
            $display("FAIL sb_rises_per_byte: got %0d expected 8", rcnt);
          end
        end
        rcnt = 0;
      end
    end
    i_MISO = (miso_q.size() > 0) ? miso_bit(miso_q[0], rcnt) : 1'b0;
  end

  // Wait for ready, queue expectations, pulse one handshake
  task automatic send(input logic [7:0] tx, input logic [7:0] miso, input logic hold);
    int w;
    w = 0;
    @(negedge clk);
    while (o_tx_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (o_tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: tx_ready=%b expected 1", o_tx_ready);
    end
    exp_tx_q.push_back(tx);
    exp_rx_q.push_back(miso);
    miso_q.push_back(miso);
    i_cs_hold  = hold;
    i_tx_data  = tx;
    i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    // reset held together with a request: reset must win
    i_sys_rst  = 1'b1;
    i_tx_valid = 1'b1;
    i_tx_data  = 8'hFF;
    repeat (3) @(negedge clk);
    vectors++;
    if (o_tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_tx_ready: got %b expected 1", o_tx_ready); end
    vectors++;
    if (o_rx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rx_valid: got %b expected 0", o_rx_valid); end
    vectors++;
    if (o_rx_data !== 8'h00) begin miscompares++; $display("FAIL rst_rx_data: got %h expected 00", o_rx_data); end
    vectors++;
    if (o_sck !== 1'b0) begin miscompares++; $display("FAIL rst_sck: got %b expected 0", o_sck); end
    vectors++;
    if (o_MOSI !== 1'b0) begin miscompares++; $display("FAIL rst_mosi: got %b expected 0", o_MOSI); end
    vectors++;
    if (o_cs !== 1'b1) begin miscompares++; $display("FAIL rst_cs: got %b expected 1", o_cs); end
    i_sys_rst  = 1'b0;
    i_tx_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_tx_ready !== 1'b1 || o_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_idle_after: ready=%b cs=%b expected 1 1", o_tx_ready, o_cs);
    end
  endtask

  task automatic test_basic();
    int cyc, cs_bad, r0;
    logic mosi_first;
    r0 = total_rises;
    send(8'hA5, 8'h3C, 1'b0);
    cyc = 1;
    cs_bad = 0;
    mosi_first = o_MOSI;
    while (o_rx_valid !== 1'b1 && cyc < 100) begin
      if (o_cs !== 1'b0) cs_bad++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (mosi_first !== miso_bit(8'hA5, 0)) begin
      miscompares++;
      $display("FAIL basic_first_mosi: got %b expected %b", mosi_first, miso_bit(8'hA5, 0));
    end
    vectors++;
    if (cyc != 33) begin miscompares++; $display("FAIL basic_latency: got %0d expected 33", cyc); end
    vectors++;
    if (cs_bad != 0 || o_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_cs_low: high_cycles=%0d cs_at_done=%b expected 0 0", cs_bad, o_cs);
    end
    vectors++;
    if (o_sck !== 1'b0) begin miscompares++; $display("FAIL basic_sck_done: got %b expected 0", o_sck); end
    vectors++;
    if (total_rises - r0 != 8) begin
      miscompares++;
      $display("FAIL basic_rises: got %0d expected 8", total_rises - r0);
    end
    @(negedge clk);
    vectors++;
    if (o_tx_ready !== 1'b1 || o_rx_valid !== 1'b0 || o_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after_done: ready=%b rx_valid=%b cs=%b expected 1 0 1", o_tx_ready, o_rx_valid, o_cs);
    end
    vectors++;
    if (o_MOSI !== miso_bit(8'hA5, 7)) begin
      miscompares++;
      $display("FAIL basic_mosi_hold: got %b expected %b", o_MOSI, miso_bit(8'hA5, 7));
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (o_rx_data !== 8'h3C) begin miscompares++; $display("FAIL basic_rx_hold: got %h expected 3c", o_rx_data); end
  endtask

  task automatic test_back_to_back(input logic hold);
    int cyc, n, cs_bad, high_between, sck_bad, r0;
    r0 = total_rises;
    exp_tx_q.push_back(8'h01); exp_rx_q.push_back(8'hC3); miso_q.push_back(8'hC3);
    exp_tx_q.push_back(8'hFF); exp_rx_q.push_back(8'h5A); miso_q.push_back(8'h5A);
    @(negedge clk);
    i_cs_hold  = hold;
    i_tx_data  = 8'h01;
    i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_data = 8'hFF;
    cyc = 0; n = 0; cs_bad = 0; high_between = 0; sck_bad = 0;
    while (n < 2 && cyc < 200) begin
      if (o_rx_valid === 1'b1) n++;
      if (n == 2) i_tx_valid = 1'b0;
      if (o_cs === 1'b1 && o_sck !== 1'b0) sck_bad++;
      if (o_cs !== 1'b0) cs_bad++;
      if (o_cs === 1'b1 && n == 1) high_between++;
      @(negedge clk);
      cyc++;
    end
    i_tx_valid = 1'b0;
    vectors++;
    if (n != 2) begin miscompares++; $display("FAIL b2b_strobes: got %0d expected 2", n); end
    vectors++;
    if (total_rises - r0 != 16) begin
      miscompares++;
      $display("FAIL b2b_rises: got %0d expected 16", total_rises - r0);
    end
    if (hold) begin
      vectors++;
      if (cs_bad != 0 || o_cs !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_hold_cs: high_cycles=%0d cs=%b expected 0 0", cs_bad, o_cs);
      end
      i_cs_hold = 1'b0;
      @(negedge clk);
      vectors++;
      if (o_cs !== 1'b1) begin miscompares++; $display("FAIL hold_release_cs: got %b expected 1", o_cs); end
    end else begin
      vectors++;
      if (high_between < 1) begin
        miscompares++;
        $display("FAIL b2b_cs_gap: got %0d cycles expected >=1", high_between);
      end
      vectors++;
      if (sck_bad != 0) begin miscompares++; $display("FAIL b2b_sck_cs_high: got %0d expected 0", sck_bad); end
      vectors++;
      if (o_cs !== 1'b1) begin miscompares++; $display("FAIL b2b_cs_end: got %b expected 1", o_cs); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, rises, s0;
    logic prev;
    send(8'hA5, 8'h3C, 1'b0);
    cyc = 0; rises = 0; prev = o_sck;
    while (rises < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (o_sck === 1'b1 && prev === 1'b0) rises++;
      prev = o_sck;
    end
    i_sys_rst = 1'b1;
    exp_rx_q.delete();
    exp_tx_q.delete();
    miso_q.delete();
    s0 = strobes;
    @(negedge clk);
    vectors++;
    if (rises != 5) begin miscompares++; $display("FAIL midrst_reach: got %0d rises expected 5", rises); end
    vectors++;
    if (o_cs !== 1'b1 || o_sck !== 1'b0 || o_tx_ready !== 1'b1 || o_rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: cs=%b sck=%b ready=%b rx_valid=%b expected 1 0 1 0",
               o_cs, o_sck, o_tx_ready, o_rx_valid);
    end
    i_sys_rst = 1'b0;
    repeat (60) @(negedge clk);
    vectors++;
    if (strobes != s0) begin miscompares++; $display("FAIL midrst_no_strobe: got %0d expected 0", strobes - s0); end
  endtask

  task automatic test_ignore_busy();
    int cyc, s0, busy_ready;
    s0 = strobes;
    send(8'hA5, 8'h96, 1'b0);
    repeat (8) @(negedge clk);
    i_tx_data  = 8'h55;
    i_tx_valid = 1'b1;
    busy_ready = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_tx_ready !== 1'b0) busy_ready++;
    end
    i_tx_valid = 1'b0;
    cyc = 0;
    while (strobes == s0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (busy_ready != 0) begin miscompares++; $display("FAIL busy_ready: got %0d ready cycles expected 0", busy_ready); end
    vectors++;
    if (strobes - s0 != 1) begin miscompares++; $display("FAIL busy_strobes: got %0d expected 1", strobes - s0); end
    vectors++;
    if (exp_rx_q.size() != 0) begin miscompares++; $display("FAIL busy_queue: got %0d pending expected 0", exp_rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back(1'b1);
    test_back_to_back(1'b0);
    test_reset_mid();
    test_ignore_busy();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
